cw305_usb_bus_initiator: RTL
============================

# cw305_usb_bus_initiator

Host-side initiator for the CW305 8-bit parallel USB register bus. It turns a simple command stream (address, direction, byte count) plus write/read byte streams into cycle-exact `usb_cen`/`usb_wrn`/`usb_rdn`/`usb_addr`/data bus cycles. It sits opposite the FPGA register front end and is used for on-chip self-test and loopback of the register map, and as the synthesizable bus model in the block-level benches.

## Interface
Parameters:
- `pADDR_WIDTH`, 21: bus address width.
- `pBYTECNT_SIZE`, 7: low address bits forming the byte-count field.
- `pSTROBE_CYCLES`, 2: `usb_wrn` low duration per write byte, ≥1.
- `pRD_LATENCY`, 4: `usb_rdn` low duration per read byte; data is sampled on the last low cycle, ≥3.

Ports:
- `usb_clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in pADDR_WIDTH: start address.
- `cmd_len` in pBYTECNT_SIZE: burst length minus 1.
- `wr_data` in 8, `wr_valid` in 1, `wr_ready` out 1: write byte stream.
- `rd_data` out 8, `rd_valid` out 1: read byte stream, one-cycle pulse, no backpressure.
- `done` out 1: one-cycle pulse at end of burst.
- `busy` out 1: high whenever state ≠ IDLE.
- `bus_err` out 1: one-cycle pulse when `usb_isout` is low at a read sample.
- `usb_addr` out pADDR_WIDTH; `usb_dout` out 8 (to target `usb_din`); `usb_din` in 8 (from target `usb_dout`); `usb_isout` in 1.
- `usb_cen`, `usb_wrn`, `usb_rdn` out 1, active-low. `usb_alen` out 1: tied 1.

## Operation
- FSM states: IDLE, WR_FETCH, SETUP, WR_STROBE, RD_STROBE, HOLD, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_addr`, `cmd_write`, `cmd_len`, and clear byte index `i`.
  - Next state is WR_FETCH for a write, SETUP for a read.
- WR_FETCH:
  - `wr_ready`=1.
  - On `wr_valid`, latch `wr_data` into `usb_dout` and go to SETUP.
  - `usb_cen` holds its previous value; strobes stay high.
- SETUP: 1 cycle. `usb_cen`=0, `usb_addr` driven, strobes high. Next state is WR_STROBE or RD_STROBE.
- WR_STROBE: `usb_wrn`=0 for pSTROBE_CYCLES cycles, then HOLD.
- RD_STROBE:
  - `usb_rdn`=0 for pRD_LATENCY cycles.
  - On the last cycle, register `usb_din` into `rd_data`; `rd_valid` pulses on the following cycle.
  - If `usb_isout`=0 on that sample cycle, pulse `bus_err` together with `rd_valid`; data is still delivered.
- HOLD: 1 cycle, strobes high, `usb_cen` stays 0.
  - If `i == len`: go to DONE.
  - Else: `i` increments, then WR_FETCH for a write, SETUP for a read.
- DONE: `usb_cen`=1, `done`=1 for 1 cycle, then IDLE. This guarantees ≥1 cycle of `usb_cen` high between commands.
- Address rule:
  - Upper bits `usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE]` are constant across the burst.
  - `usb_addr[pBYTECNT_SIZE-1:0] = (start_bytecnt + i) mod 2^pBYTECNT_SIZE`. Wrap stays inside the register; there is no carry into the upper bits.
- Only one of `usb_wrn`/`usb_rdn` is ever low, and never in the same cycle as an address change.

## Timing
- Reset values: `usb_cen`=`usb_wrn`=`usb_rdn`=`usb_alen`=1; `usb_addr`=0; `usb_dout`=0; `rd_data`=0; `cmd_ready`=0 during reset, then 1 in IDLE; `wr_ready`=`rd_valid`=`done`=`busy`=`bus_err`=0.
- All outputs are registered.
- Reset mid-burst: at the next edge all strobes and `usb_cen` go high and the state returns to IDLE. The partial burst is discarded with no `done`.
- Write byte: 1 (SETUP) + pSTROBE_CYCLES + 1 (HOLD) cycles, i.e. 4 at defaults, plus WR_FETCH cycles (≥1).
- Read byte: 1 + pRD_LATENCY + 1 cycles, i.e. 6 at defaults.
- Command accept to first `usb_cen` low: 1 cycle for a read, 2 cycles for a write with `wr_valid` already high.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- A write stream stalled indefinitely keeps the FSM in WR_FETCH with `usb_cen` low.

## Structure
- Shared package `cw305_usb_pkg` holds:
  - the state enumeration;
  - default widths (ADDR 21, BYTECNT 7), shared with the register front end;
  - the `usb_alen` inactive constant.
- One sub-module, `cw305_usb_strobe_timer`: a loadable down-counter producing a last-cycle flag, used by both WR_STROBE and RD_STROBE.

## Test plan
- **Single write:** cmd_addr=0x00180, len=0, write, wr_data=0xA5. Expect `usb_cen` low for 4 cycles, `usb_wrn` low for 2 cycles with `usb_dout`=0xA5 and `usb_addr`=0x00180, then one `done` pulse.
- **4-byte read:** addr=0x0007E, len=3, target returning bytecnt as data. Expect addresses 0x7E, 0x7F, 0x00, 0x01 (bytecnt wrap, upper bits 0); `rd_data` 0x7E, 0x7F, 0x00, 0x01; 4 `rd_valid` pulses, 6 cycles apart.
- **Write backpressure:** len=2, `wr_valid` dropped for 5 cycles before byte 1. Expect the FSM to hold in WR_FETCH with strobes high, with no extra or duplicated `usb_wrn` pulse.
- **Isout fault:** read with `usb_isout` forced 0. Expect `bus_err` and `rd_valid` to pulse together, with `done` still issued.
- **Reset mid-read:** `rst` asserted during RD_STROBE. Expect `usb_rdn`=`usb_cen`=1 at the next edge, no `done`, and a new command accepted after reset.
- **Back-to-back commands:** a second `cmd_valid` held high. Expect ≥1 cycle of `usb_cen` high between bursts and `cmd_ready` high only in IDLE.

Source files
------------

// File: rtl/cw305_usb_pkg.sv
// Shared definitions for the CW305 parallel USB register bus.
// Holds the default address/byte-count widths (common with the register
// front end), the inactive level of usb_alen and the initiator state set.
package cw305_usb_pkg;

    localparam int unsigned USB_ADDR_WIDTH    = 21;
    localparam int unsigned USB_BYTECNT_SIZE  = 7;
    localparam logic        USB_ALEN_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_FETCH  = 3'd1,
        SETUP     = 3'd2,
        WR_STROBE = 3'd3,
        RD_STROBE = 3'd4,
        HOLD      = 3'd5,
        DONE      = 3'd6
    } usb_init_state_t;

endpackage

// File: rtl/cw305_usb_strobe_timer.sv
// Loadable down-counter timing the low phase of usb_wrn / usb_rdn.
// Ports:
//   usb_clk, rst  : clock, synchronous active-high reset
//   load          : load load_value this edge (load_value = cycles - 1)
//   load_value    : reload count
//   last_c        : combinational flag, high on the final strobe cycle
module cw305_usb_strobe_timer #(
    parameter int unsigned pWIDTH = 3
) (
    input  logic              usb_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_value,
    output logic              last_c
);

    logic [pWIDTH-1:0] count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - pWIDTH'(1);
        end
    end

    assign last_c = (count == '0);

endmodule

// File: rtl/cw305_usb_bus_initiator.sv
// Host-side initiator for the CW305 8-bit parallel USB register bus.
// Converts a command stream (address, direction, length) plus write/read byte
// streams into cycle-exact usb_cen/usb_wrn/usb_rdn/usb_addr/data bus cycles.
// Ports:
//   usb_clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write, cmd_addr, cmd_len     : direction, start address, length-1
//   wr_data/wr_valid/wr_ready        : write byte stream
//   rd_data/rd_valid                 : read byte stream (pulse, no backpressure)
//   done, busy, bus_err              : burst end pulse, activity, isout fault
//   usb_addr, usb_dout, usb_din      : bus address and data
//   usb_isout                        : target drive indication
//   usb_cen, usb_wrn, usb_rdn        : active-low bus strobes
//   usb_alen                         : address latch enable, held inactive
module cw305_usb_bus_initiator
    import cw305_usb_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH    = USB_ADDR_WIDTH,
    parameter int unsigned pBYTECNT_SIZE  = USB_BYTECNT_SIZE,
    parameter int unsigned pSTROBE_CYCLES = 2,
    parameter int unsigned pRD_LATENCY    = 4
) (
    input  logic                     usb_clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [pADDR_WIDTH-1:0]   cmd_addr,
    input  logic [pBYTECNT_SIZE-1:0] cmd_len,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     done,
    output logic                     busy,
    output logic                     bus_err,
    output logic [pADDR_WIDTH-1:0]   usb_addr,
    output logic [7:0]               usb_dout,
    input  logic [7:0]               usb_din,
    input  logic                     usb_isout,
    output logic                     usb_cen,
    output logic                     usb_wrn,
    output logic                     usb_rdn,
    output logic                     usb_alen
);

    localparam int unsigned TMR_MAX = (pRD_LATENCY > pSTROBE_CYCLES) ? pRD_LATENCY : pSTROBE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    usb_init_state_t state, state_d;

    logic                     write_q, write_d;
    logic [pBYTECNT_SIZE-1:0] len_q, len_d;
    logic [pBYTECNT_SIZE-1:0] idx_q, idx_d;

    logic [pADDR_WIDTH-1:0]   usb_addr_d;
    logic [7:0]               usb_dout_d;
    logic [7:0]               rd_data_d;
    logic                     rd_valid_d;
    logic                     bus_err_d;
    logic                     cmd_ready_d;
    logic                     wr_ready_d;
    logic                     done_d;
    logic                     busy_d;
    logic                     usb_cen_d;
    logic                     usb_wrn_d;
    logic                     usb_rdn_d;

    logic                     tmr_load;
    logic [TMR_W-1:0]         tmr_value;
    logic                     tmr_last;

    assign usb_alen = USB_ALEN_INACTIVE;

    cw305_usb_strobe_timer #(
        .pWIDTH (TMR_W)
    ) u_strobe_timer (
        .usb_clk    (usb_clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .last_c     (tmr_last)
    );

    // State register.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, burst bookkeeping and next values of the registered outputs.
    // Outputs are derived from state_d so each registered output lines up
    // with the state it belongs to.
    always_comb begin
        state_d    = state;
        write_d    = write_q;
        len_d      = len_q;
        idx_d      = idx_q;
        usb_addr_d = usb_addr;
        usb_dout_d = usb_dout;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        case (state)
            IDLE: begin
                // cmd_ready is low for one cycle after reset; honour it.
                if (cmd_valid && cmd_ready) begin
                    usb_addr_d = cmd_addr;
                    write_d    = cmd_write;
                    len_d      = cmd_len;
                    idx_d      = '0;
                    state_d    = cmd_write ? WR_FETCH : SETUP;
                end
            end
            WR_FETCH: begin
                if (wr_valid && wr_ready) begin
                    usb_dout_d = wr_data;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                tmr_load = 1'b1;
                if (write_q) begin
                    tmr_value = TMR_W'(pSTROBE_CYCLES - 1);
                    state_d   = WR_STROBE;
                end else begin
                    tmr_value = TMR_W'(pRD_LATENCY - 1);
                    state_d   = RD_STROBE;
                end
            end
            WR_STROBE: begin
                if (tmr_last) begin
                    state_d = HOLD;
                end
            end
            RD_STROBE: begin
                // Sample on the last low cycle; the fault flag rides with the data.
                if (tmr_last) begin
                    rd_data_d  = usb_din;
                    rd_valid_d = 1'b1;
                    bus_err_d  = ~usb_isout;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (idx_q == len_q) begin
                    state_d = DONE;
                end else begin
                    // Byte-count field wraps inside itself; upper bits never change.
                    idx_d      = idx_q + pBYTECNT_SIZE'(1);
                    usb_addr_d = {usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE],
                                  usb_addr[pBYTECNT_SIZE-1:0] + pBYTECNT_SIZE'(1)};
                    state_d    = write_q ? WR_FETCH : SETUP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        wr_ready_d  = (state_d == WR_FETCH);
        done_d      = (state_d == DONE);
        usb_wrn_d   = (state_d != WR_STROBE);
        usb_rdn_d   = (state_d != RD_STROBE);

        // usb_cen keeps its level while waiting for write data.
        case (state_d)
            IDLE, DONE: usb_cen_d = 1'b1;
            WR_FETCH:   usb_cen_d = usb_cen;
            default:    usb_cen_d = 1'b0;
        endcase
    end

    // Registered outputs and burst context.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            write_q   <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            usb_addr  <= '0;
            usb_dout  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            bus_err   <= 1'b0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            usb_cen   <= 1'b1;
            usb_wrn   <= 1'b1;
            usb_rdn   <= 1'b1;
        end else begin
            write_q   <= write_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            usb_addr  <= usb_addr_d;
            usb_dout  <= usb_dout_d;
            rd_data   <= rd_data_d;
            rd_valid  <= rd_valid_d;
            bus_err   <= bus_err_d;
            cmd_ready <= cmd_ready_d;
            wr_ready  <= wr_ready_d;
            done      <= done_d;
            busy      <= busy_d;
            usb_cen   <= usb_cen_d;
            usb_wrn   <= usb_wrn_d;
            usb_rdn   <= usb_rdn_d;
        end
    end

endmodule
